and_rr_scheduler: RTL and testbench



---
 rtl/and_rr_scheduler.sv | 104 ++++++++++
 tb/tb_and_rr_scheduler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/and_rr_scheduler.sv
// Round-robin scheduler that time-shares one DW-bit AND unit among N_REQ
// requesters, returning each result tagged with the owning requester's index.
module and_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_a,
  input  logic [N_REQ*DW-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [DW-1:0]       rsp_data,
  output logic                alu_enable,
  output logic [DW-1:0]       alu_a,
  output logic [DW-1:0]       alu_b,
  input  logic [DW-1:0]       alu_out,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] grant_idx;
  logic           grant_found;
  logic           accept;
  int             cand;

  // Search starts one past the previous winner and wraps, so every
  // continuously valid requester is reached within N_REQ grants.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = int'(last_grant) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!grant_found && req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  assign accept    = (state == IDLE) && grant_found;
  assign req_ready = accept ? (N_REQ'(1) << grant_idx) : '0;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDW'(N_REQ - 1);
      rsp_id     <= '0;
      rsp_data   <= '0;
      alu_enable <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a  <= req_a[grant_idx*DW +: DW];
            alu_b  <= req_b[grant_idx*DW +: DW];
            rsp_id <= grant_idx;
          end
        end
        // The AND unit evaluates on any edge of enable, so toggling is the trigger.
        ISSUE:   alu_enable <= ~alu_enable;
        CAPTURE: rsp_data   <= alu_out;
        RESP:    if (rsp_ready) last_grant <= rsp_id;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_and_rr_scheduler.sv
// Self-checking bench for and_rr_scheduler: vector table for single operations,
// hand-written sequences for round-robin, backpressure and mid-operation reset.
module tb_and_rr_scheduler;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_data;
  logic           alu_enable;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [W-1:0]   alu_out = '0;
  logic           busy;

  and_rr_scheduler #(.N_REQ(N), .DW(W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .alu_enable(alu_enable), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural and_dut: re-evaluates only when enable changes.
  always @(alu_enable) alu_out = alu_a & alu_b;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
  } rsp_t;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] a;
    logic [31:0] b;
    int          id;
    logic [7:0]  data;
  } vec_t;

  rsp_t sb[$];
  rsp_t mon_e;
  vec_t vt[7];
  int   n_pass = 0;
  int   n_total = 0;
  logic exp_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Response scoreboard: every completed response handshake pops one entry.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        check("rsp_data", 32'(rsp_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // One full operation with rsp_ready high, starting from IDLE.
  task automatic do_op(input vec_t v);
    logic [7:0] ea;
    ea = v.a[v.id*8 +: 8];
    req_valid = v.mask;
    req_a     = v.a;
    req_b     = v.b;
    rsp_ready = 1'b1;
    sb.push_back('{id: 2'(v.id), data: v.data});
    mid();
    check("grant", 32'(req_ready), 32'(1) << v.id);
    check("idle_busy", 32'(busy), 32'd0);
    tick();
    req_valid = '0;
    mid();
    check("issue_busy", 32'(busy), 32'd1);
    check("issue_ready", 32'(req_ready), 32'd0);
    check("issue_alu_a", 32'(alu_a), 32'(ea));
    check("issue_en", 32'(alu_enable), 32'(exp_en));
    tick();
    exp_en = ~exp_en;
    mid();
    check("toggle_en", 32'(alu_enable), 32'(exp_en));
    check("capture_valid", 32'(rsp_valid), 32'd0);
    tick();
    mid();
    check("resp_valid", 32'(rsp_valid), 32'd1);
    tick();
    mid();
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    int          ord[5];

    vt[0] = '{mask: 4'b0100, a: 32'h00F0_0000, b: 32'h003C_0000, id: 2, data: 8'h30};
    vt[1] = '{mask: 4'b0010, a: 32'h0000_FF00, b: 32'h0000_0000, id: 1, data: 8'h00};
    vt[2] = '{mask: 4'b1000, a: 32'hFF00_0000, b: 32'hFF00_0000, id: 3, data: 8'hFF};
    vt[3] = '{mask: 4'b1001, a: 32'hF000_00AA, b: 32'hFF00_0055, id: 0, data: 8'h00};
    vt[4] = '{mask: 4'b1001, a: 32'hF000_00AA, b: 32'hFF00_0055, id: 3, data: 8'hF0};
    vt[5] = '{mask: 4'b0001, a: 32'h0000_005A, b: 32'h0000_000F, id: 0, data: 8'h0A};
    vt[6] = '{mask: 4'b0110, a: 32'h00FF_C300, b: 32'h00FF_F000, id: 1, data: 8'hC0};

    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    exp_en = 1'b0;
    tick();
    tick();
    mid();
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_id", 32'(rsp_id), 32'd0);
    check("rst_data", 32'(rsp_data), 32'd0);
    check("rst_en", 32'(alu_enable), 32'd0);
    check("rst_alu_a", 32'(alu_a), 32'd0);
    check("rst_alu_b", 32'(alu_b), 32'd0);
    tick();
    rst = 1'b0;

    // All four valid with rsp_ready high: grants 0,1,2,3,0 spaced 4 cycles.
    ra = 32'h3CAA_0FF0;
    rb = 32'hE75A_FFCC;
    ord = '{0, 1, 2, 3, 0};
    req_valid = 4'b1111;
    req_a = ra;
    req_b = rb;
    rsp_ready = 1'b1;
    foreach (ord[k]) sb.push_back('{id: 2'(ord[k]), data: ra[ord[k]*8 +: 8] & rb[ord[k]*8 +: 8]});
    for (int k = 0; k < 5; k++) begin
      mid();
      check("rr_grant", 32'(req_ready), 32'(1) << ord[k]);
      repeat (4) @(posedge clk);
      exp_en = ~exp_en;
    end
    #1;
    req_valid = '0;
    mid();
    check("rr_en", 32'(alu_enable), 32'(exp_en));
    check("rr_drain", 32'(sb.size()), 32'd0);
    tick();

    foreach (vt[i]) do_op(vt[i]);

    // Backpressure: response held for 10 cycles with everyone requesting.
    req_valid = 4'b0010;
    req_a = 32'h0000_9900;
    req_b = 32'h0000_F500;
    rsp_ready = 1'b0;
    sb.push_back('{id: 2'd1, data: 8'h91});
    mid();
    check("bp_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b1111;
    tick();
    tick();
    exp_en = ~exp_en;
    for (int c = 0; c < 10; c++) begin
      mid();
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id", 32'(rsp_id), 32'd1);
      check("bp_data", 32'(rsp_data), 32'h91);
      check("bp_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    mid();
    tick();
    mid();
    check("bp_release_valid", 32'(rsp_valid), 32'd0);
    check("bp_release_busy", 32'(busy), 32'd0);
    check("bp_drain", 32'(sb.size()), 32'd0);
    tick();

    // Reset during CAPTURE: in-flight result discarded, priority restarts at 0.
    req_valid = 4'b0100;
    req_a = 32'h0077_0000;
    req_b = 32'h00FF_0000;
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    #1;
    check("mrst_valid", 32'(rsp_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_en", 32'(alu_enable), 32'd0);
    check("mrst_alu_a", 32'(alu_a), 32'd0);
    check("mrst_id", 32'(rsp_id), 32'd0);
    check("mrst_data", 32'(rsp_data), 32'd0);
    tick();
    tick();
    mid();
    check("mrst_hold_valid", 32'(rsp_valid), 32'd0);
    tick();
    rst = 1'b0;
    exp_en = 1'b0;
    do_op('{mask: 4'b1111, a: 32'h8040_2010, b: 32'hFFFF_FFFF, id: 0, data: 8'h10});

    check("final_drain", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
